// File: rtl/rot_meas_seq_if.sv
// Control/status bundle between the host register block and the rotation measurement sequencer.
// The master side drives the run controls; the slave side is the sequencer.
interface rot_meas_seq_if #(
  parameter int N_CH  = 4,
  parameter int ROT_W = 10
);
  logic             trg_ctrl;
  logic             pause_ctrl;
  logic [N_CH-1:0]  ch_mask;
  logic             wrk_stat;
  logic             rot_en;
  logic             adc_en;
  logic [N_CH-1:0]  rf_sw;
  logic [3:0]       ch_idx;
  logic [ROT_W-1:0] rot_count;
  logic             pause_out;
  logic             done;

  modport master (
    output trg_ctrl, pause_ctrl, ch_mask,
    input  wrk_stat, rot_en, adc_en, rf_sw, ch_idx, rot_count, pause_out, done
  );

  modport slave (
    input  trg_ctrl, pause_ctrl, ch_mask,
    output wrk_stat, rot_en, adc_en, rf_sw, ch_idx, rot_count, pause_out, done
  );
endinterface

// File: rtl/rot_meas_seq.sv
// Rotation / RF-switch / ADC measurement sequencer: per rotation step pulses the rotator, dwells,
// then settles and acquires on every enabled channel in ascending order, for N_ROT steps.
module rot_meas_seq #(
  parameter int N_CH     = 4,
  parameter int CLK_DIV  = 1000000,
  parameter int T_RDLY   = 1,
  parameter int T_ROT    = 5,
  parameter int T_DWELL  = 100,
  parameter int T_SETTLE = 3,
  parameter int T_ACQ    = 30,
  parameter int N_ROT    = 720,
  parameter int ROT_W    = 10
) (
  input  logic             fpga_clk,
  input  logic             sys_rst_n,
  input  logic             sys_init_ctrl,
  rot_meas_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RDLY, S_ROT, S_DWELL, S_SETTLE, S_ACQ, S_PAUSED, S_DONE
  } state_t;

  // Timers count down from (duration - 1) so a state lasts exactly T_x*CLK_DIV cycles.
  localparam logic [31:0] L_RDLY   = 32'(T_RDLY   * CLK_DIV - 1);
  localparam logic [31:0] L_ROT    = 32'(T_ROT    * CLK_DIV - 1);
  localparam logic [31:0] L_DWELL  = 32'(T_DWELL  * CLK_DIV - 1);
  localparam logic [31:0] L_SETTLE = 32'(T_SETTLE * CLK_DIV - 1);
  localparam logic [31:0] L_ACQ    = 32'(T_ACQ    * CLK_DIV - 1);
  localparam logic [ROT_W-1:0] L_NROT = ROT_W'(N_ROT);

  // Lowest set bit of mask at or above index lo; bit 4 of the result flags a hit.
  function automatic logic [4:0] find_ch(input logic [N_CH-1:0] mask, input int lo);
    logic [4:0] res;
    res = 5'd0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [3:0] idx);
    return N_CH'(1'b1) << idx;
  endfunction

  state_t           r_state, w_next_state, r_ret_state, w_ret_nxt;
  logic [31:0]      r_timer, w_timer_nxt;
  logic             r_pause_req, w_pause_req_nxt;
  logic [N_CH-1:0]  r_eff_mask, w_eff_mask_nxt;
  logic [N_CH-1:0]  r_rf_sw, w_rf_sw_nxt;
  logic [3:0]       r_ch_idx, w_ch_idx_nxt;
  logic [ROT_W-1:0] r_rot_count, w_rot_count_nxt, w_count_inc;
  logic             w_done_nxt;
  logic [4:0]       w_sel;
  logic             r_wrk_stat, r_rot_en, r_adc_en, r_pause_out, r_done;

  // State register.
  always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else if (sys_init_ctrl) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, timer and datapath updates.
  always_comb begin
    w_next_state    = r_state;
    w_ret_nxt       = r_ret_state;
    w_timer_nxt     = r_timer;
    w_pause_req_nxt = r_pause_req;
    w_eff_mask_nxt  = r_eff_mask;
    w_rf_sw_nxt     = r_rf_sw;
    w_ch_idx_nxt    = r_ch_idx;
    w_rot_count_nxt = r_rot_count;
    w_done_nxt      = 1'b0;
    w_sel           = 5'd0;
    w_count_inc     = r_rot_count + ROT_W'(1);

    if (bus.pause_ctrl && r_wrk_stat) begin
      w_pause_req_nxt = 1'b1;
    end else begin
      w_pause_req_nxt = r_pause_req;
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.trg_ctrl) begin
          w_next_state    = S_RDLY;
          w_timer_nxt     = L_RDLY;
          w_rot_count_nxt = '0;
        end else begin
          w_next_state = r_state;
        end
      end
      S_RDLY: begin
        if (r_timer == 32'd0) begin
          w_next_state = S_ROT;
          w_timer_nxt  = L_ROT;
        end else begin
          w_timer_nxt = r_timer - 32'd1;
        end
      end
      S_ROT: begin
        if (r_timer == 32'd0) begin
          w_next_state   = S_DWELL;
          w_timer_nxt    = L_DWELL;
          w_eff_mask_nxt = (bus.ch_mask == '0) ? {N_CH{1'b1}} : bus.ch_mask;
        end else begin
          w_timer_nxt = r_timer - 32'd1;
        end
      end
      S_DWELL, S_SETTLE: begin
        w_sel = find_ch(r_eff_mask, 0);
        if (r_pause_req) begin
          // The cycle spent here still counts; the timer then stays frozen while paused.
          w_next_state    = S_PAUSED;
          w_ret_nxt       = r_state;
          w_pause_req_nxt = 1'b0;
          w_timer_nxt     = (r_timer == 32'd0) ? 32'd0 : r_timer - 32'd1;
        end else if (r_timer != 32'd0) begin
          w_timer_nxt = r_timer - 32'd1;
        end else if (r_state == S_DWELL) begin
          w_next_state = S_SETTLE;
          w_timer_nxt  = L_SETTLE;
          w_ch_idx_nxt = w_sel[3:0];
          w_rf_sw_nxt  = onehot(w_sel[3:0]);
        end else begin
          w_next_state = S_ACQ;
          w_timer_nxt  = L_ACQ;
        end
      end
      S_ACQ: begin
        w_sel = find_ch(r_eff_mask, int'(r_ch_idx) + 1);
        if (r_timer != 32'd0) begin
          w_timer_nxt = r_timer - 32'd1;
        end else if (w_sel[4]) begin
          w_next_state = S_SETTLE;
          w_timer_nxt  = L_SETTLE;
          w_ch_idx_nxt = w_sel[3:0];
          w_rf_sw_nxt  = onehot(w_sel[3:0]);
        end else begin
          w_rf_sw_nxt     = '0;
          w_rot_count_nxt = w_count_inc;
          if (w_count_inc == L_NROT) begin
            w_next_state    = S_DONE;
            w_done_nxt      = 1'b1;
            w_pause_req_nxt = 1'b0;
          end else begin
            w_next_state = S_RDLY;
            w_timer_nxt  = L_RDLY;
          end
        end
      end
      S_PAUSED: begin
        if (bus.trg_ctrl) begin
          w_next_state = r_ret_state;
        end else begin
          w_next_state = S_PAUSED;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs, decoded from the next state.
  always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ret_state <= S_IDLE;
      r_timer     <= 32'd0;
      r_pause_req <= 1'b0;
      r_eff_mask  <= '0;
      r_rf_sw     <= '0;
      r_ch_idx    <= 4'd0;
      r_rot_count <= '0;
      r_wrk_stat  <= 1'b0;
      r_rot_en    <= 1'b0;
      r_adc_en    <= 1'b0;
      r_pause_out <= 1'b0;
      r_done      <= 1'b0;
    end else if (sys_init_ctrl) begin
      r_ret_state <= S_IDLE;
      r_timer     <= 32'd0;
      r_pause_req <= 1'b0;
      r_eff_mask  <= '0;
      r_rf_sw     <= '0;
      r_ch_idx    <= 4'd0;
      r_rot_count <= '0;
      r_wrk_stat  <= 1'b0;
      r_rot_en    <= 1'b0;
      r_adc_en    <= 1'b0;
      r_pause_out <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ret_state <= w_ret_nxt;
      r_timer     <= w_timer_nxt;
      r_pause_req <= w_pause_req_nxt;
      r_eff_mask  <= w_eff_mask_nxt;
      r_rf_sw     <= w_rf_sw_nxt;
      r_ch_idx    <= w_ch_idx_nxt;
      r_rot_count <= w_rot_count_nxt;
      r_wrk_stat  <= (w_next_state == S_RDLY) || (w_next_state == S_ROT) ||
                     (w_next_state == S_DWELL) || (w_next_state == S_SETTLE) ||
                     (w_next_state == S_ACQ);
      r_rot_en    <= (w_next_state == S_ROT);
      r_adc_en    <= (w_next_state == S_ACQ);
      r_pause_out <= (w_next_state == S_PAUSED);
      r_done      <= w_done_nxt;
    end
  end

  assign bus.wrk_stat  = r_wrk_stat;
  assign bus.rot_en    = r_rot_en;
  assign bus.adc_en    = r_adc_en;
  assign bus.rf_sw     = r_rf_sw;
  assign bus.ch_idx    = r_ch_idx;
  assign bus.rot_count = r_rot_count;
  assign bus.pause_out = r_pause_out;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_rot_meas_seq.sv
// Directed bench for rot_meas_seq with a short timing profile: table of full runs per mask,
// then hand-written pause, reset, soft-clear and mask-change sequences.
module tb_rot_meas_seq;

  logic fpga_clk = 1'b0;
  logic sys_rst_n;
  logic sys_init_ctrl;
  int   n_chk  = 0;
  int   n_fail = 0;

  rot_meas_seq_if #(.N_CH(4), .ROT_W(4)) ifc ();

  rot_meas_seq #(
    .N_CH(4), .CLK_DIV(2), .T_RDLY(1), .T_ROT(2), .T_DWELL(3),
    .T_SETTLE(1), .T_ACQ(2), .N_ROT(3), .ROT_W(4)
  ) dut (
    .fpga_clk      (fpga_clk),
    .sys_rst_n     (sys_rst_n),
    .sys_init_ctrl (sys_init_ctrl),
    .bus           (ifc.slave)
  );

  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    logic [3:0]  mask;
    int          nch;
    logic [15:0] seq;    // expected rf_sw per burst, first burst in [3:0]
    int          total;  // cycles from start edge to done
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge fpga_clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, ifc.wrk_stat, ifc.rot_en, ifc.adc_en, ifc.rf_sw, ifc.ch_idx,
            ifc.rot_count, ifc.pause_out, ifc.done};
  endfunction

  task automatic start_run(input logic [3:0] mask);
    ifc.ch_mask  = mask;
    ifc.trg_ctrl = 1'b1;
    step();
    ifc.trg_ctrl = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!ifc.done && n < 500) begin
      step();
      n++;
    end
    chk({name, "_done"}, 32'(ifc.done), 32'd1);
    chk({name, "_count"}, 32'(ifc.rot_count), 32'd3);
  endtask

  task automatic run_vector(input vec_t v, input int vi);
    int k, rot_hi, rot_b, adc_hi, adc_b, first_rot, first_adc, sw_err;
    logic prev_rot, prev_adc;
    k = 0; rot_hi = 0; rot_b = 0; adc_hi = 0; adc_b = 0; sw_err = 0;
    first_rot = -1; first_adc = -1; prev_rot = 1'b0; prev_adc = 1'b0;
    start_run(v.mask);
    chk($sformatf("v%0d_start_count", vi), 32'(ifc.rot_count), 32'd0);
    chk($sformatf("v%0d_start_wrk", vi), 32'(ifc.wrk_stat), 32'd1);
    while (!ifc.done && k < 400) begin
      if (ifc.rot_en) begin
        rot_hi++;
        if (!prev_rot) begin
          rot_b++;
          if (first_rot < 0) first_rot = k;
        end
      end
      if (ifc.adc_en) begin
        adc_hi++;
        if (!prev_adc) begin
          if (first_adc < 0) first_adc = k;
          if (ifc.rf_sw !== v.seq[((adc_b % v.nch) * 4) +: 4]) sw_err++;
          adc_b++;
        end
      end
      prev_rot = ifc.rot_en;
      prev_adc = ifc.adc_en;
      step();
      k++;
    end
    chk($sformatf("v%0d_total_cycles", vi), 32'(k), 32'(v.total));
    chk($sformatf("v%0d_rot_hi", vi), 32'(rot_hi), 32'd12);
    chk($sformatf("v%0d_rot_bursts", vi), 32'(rot_b), 32'd3);
    chk($sformatf("v%0d_first_rot", vi), 32'(first_rot), 32'd2);
    chk($sformatf("v%0d_first_adc", vi), 32'(first_adc), 32'd14);
    chk($sformatf("v%0d_adc_hi", vi), 32'(adc_hi), 32'(12 * v.nch));
    chk($sformatf("v%0d_adc_bursts", vi), 32'(adc_b), 32'(3 * v.nch));
    chk($sformatf("v%0d_rf_sw_seq_errs", vi), 32'(sw_err), 32'd0);
    chk($sformatf("v%0d_done_count", vi), 32'(ifc.rot_count), 32'd3);
    chk($sformatf("v%0d_done_wrk", vi), 32'(ifc.wrk_stat), 32'd0);
    step();
    chk($sformatf("v%0d_done_pulse_width", vi), 32'(ifc.done), 32'd0);
    chk($sformatf("v%0d_count_hold", vi), 32'(ifc.rot_count), 32'd3);
  endtask

  initial begin
    vecs[0] = '{mask: 4'b0101, nch: 2, seq: 16'h0041, total: 72};
    vecs[1] = '{mask: 4'b0000, nch: 4, seq: 16'h8421, total: 108};
    vecs[2] = '{mask: 4'b1000, nch: 1, seq: 16'h0008, total: 54};
    vecs[3] = '{mask: 4'b1111, nch: 4, seq: 16'h8421, total: 108};
    vecs[4] = '{mask: 4'b0110, nch: 2, seq: 16'h0042, total: 72};

    sys_rst_n      = 1'b0;
    sys_init_ctrl  = 1'b0;
    ifc.trg_ctrl   = 1'b0;
    ifc.pause_ctrl = 1'b0;
    ifc.ch_mask    = 4'b0000;
    #12;
    chk("reset_outputs", outs(), 32'd0);
    sys_rst_n = 1'b1;
    step();
    step();
    chk("idle_outputs", outs(), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_vector(vecs[i], i);
    end

    // Pause raised during ACQ: acquisition completes, pause lands in the next SETTLE.
    start_run(4'b0101);
    repeat (14) step();
    chk("p_acq_hi", 32'(ifc.adc_en), 32'd1);
    ifc.pause_ctrl = 1'b1;
    step();
    ifc.pause_ctrl = 1'b0;
    repeat (2) step();
    chk("p_acq_full", 32'(ifc.adc_en), 32'd1);
    step();
    chk("p_settle_sw", 32'(ifc.rf_sw), 32'h4);
    chk("p_settle_wrk", 32'(ifc.wrk_stat), 32'd1);
    step();
    chk("p_paused_out", 32'(ifc.pause_out), 32'd1);
    chk("p_paused_wrk", 32'(ifc.wrk_stat), 32'd0);
    chk("p_paused_sw", 32'(ifc.rf_sw), 32'h4);
    chk("p_paused_adc", 32'(ifc.adc_en), 32'd0);
    repeat (3) step();
    chk("p_still_paused", 32'(ifc.pause_out), 32'd1);
    ifc.trg_ctrl = 1'b1;
    step();
    ifc.trg_ctrl = 1'b0;
    chk("p_resume_settle", {30'd0, ifc.pause_out, ifc.adc_en}, 32'd0);
    chk("p_resume_wrk", 32'(ifc.wrk_stat), 32'd1);
    step();
    chk("p_resume_acq", 32'(ifc.adc_en), 32'd1);

    // Asynchronous reset in the middle of ACQ.
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 32'd0);
    #10;
    sys_rst_n = 1'b1;
    step();
    chk("after_reset_idle", outs(), 32'd0);

    // Pause requested in RDLY, honoured at the first DWELL cycle, then soft-cleared.
    start_run(4'b0011);
    chk("i_start_wrk", 32'(ifc.wrk_stat), 32'd1);
    ifc.pause_ctrl = 1'b1;
    step();
    ifc.pause_ctrl = 1'b0;
    repeat (6) step();
    chk("i_paused_in_dwell", 32'(ifc.pause_out), 32'd1);
    sys_init_ctrl = 1'b1;
    step();
    sys_init_ctrl = 1'b0;
    chk("i_init_outputs", outs(), 32'd0);
    start_run(4'b0011);
    repeat (7) step();
    chk("i_no_stale_pause", 32'(ifc.pause_out), 32'd0);
    chk("i_dwell_wrk", 32'(ifc.wrk_stat), 32'd1);
    wait_done("i_run");

    // Mask rewritten during ACQ of ch0: only the next DWELL entry picks it up.
    start_run(4'b0001);
    repeat (14) step();
    chk("m_acq_ch0", {28'd0, ifc.rf_sw}, 32'h1);
    ifc.ch_mask = 4'b1000;
    repeat (4) step();
    chk("m_rot1_sw_off", 32'(ifc.rf_sw), 32'd0);
    chk("m_rot1_count", 32'(ifc.rot_count), 32'd1);
    repeat (12) step();
    chk("m_rot2_sw", 32'(ifc.rf_sw), 32'h8);
    chk("m_rot2_idx", 32'(ifc.ch_idx), 32'd3);
    wait_done("m_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
